recoded_to_ieee_pipe: RTL and testbench

RECODED_TO_IEEE_PIPE -- requirements
Module: recoded_to_ieee_pipe

---
 rtl/recoded_to_ieee_pkg.sv | 35 +++
 rtl/recoded_to_ieee_lane.sv | 82 ++++++++
 rtl/recoded_to_ieee_pipe.sv | 108 ++++++++++
 tb/tb_recoded_to_ieee_pipe.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/recoded_to_ieee_pkg.sv
// Shared definitions for the recoded-to-IEEE floating-point converter.
//   - ceil_log2   : constant helper for sizing counters/indices
//   - REC_CLS_*   : top-bit class encodings of the recoded exponent
//   - rec_bias    : the B+1 bias (B = 2^(EXP_SIZE-1)) removed from normal exponents
//   - lane_class_e: per-lane decoded class
package recoded_to_ieee_pkg;

  // Recoded exponent top bits: 000 = zero, 11x = special, 111 = NaN.
  localparam logic [2:0] REC_CLS_ZERO    = 3'b000;
  localparam logic [1:0] REC_CLS_SPECIAL = 2'b11;
  localparam logic [2:0] REC_CLS_NAN     = 3'b111;

  typedef enum logic [2:0] {
    LC_ZERO,
    LC_SUBNORMAL,
    LC_NORMAL,
    LC_INF,
    LC_NAN
  } lane_class_e;

  function automatic int ceil_log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // B+1, the offset between recoded and IEEE exponents for normal numbers.
  function automatic int rec_bias(input int exp_size);
    return (1 << (exp_size - 1)) + 1;
  endfunction

endpackage

// File: rtl/recoded_to_ieee_lane.sv
// Combinational conversion of one recoded float (sign, EXP_SIZE+1 exponent,
// SIG_SIZE-1 fraction) into IEEE format.
// Ports:
//   rec_i   : recoded value, SIZE+1 bits (SIZE = EXP_SIZE+SIG_SIZE)
//   value_o : IEEE value, SIZE bits
//   snan_o  : input is a signalling NaN (fraction MSB clear)
module recoded_to_ieee_lane
  import recoded_to_ieee_pkg::*;
#(
  parameter int EXP_SIZE  = 8,
  parameter int SIG_SIZE  = 24,
  parameter int CANON_NAN = 0
) (
  input  logic [EXP_SIZE+SIG_SIZE:0]   rec_i,
  output logic [EXP_SIZE+SIG_SIZE-1:0] value_o,
  output logic                         snan_o
);

  localparam int SIZE    = EXP_SIZE + SIG_SIZE;
  localparam int EW      = EXP_SIZE + 1;
  localparam int FW      = SIG_SIZE - 1;
  localparam int BIAS_P1 = rec_bias(EXP_SIZE);
  localparam int B       = BIAS_P1 - 1;
  localparam int NORM_LO = B + 2;
  localparam int NORM_HI = 3 * B;            // exclusive
  localparam int SUB_LO  = B - SIG_SIZE + 3;
  localparam int SUB_HI  = B + 1;
  localparam logic [SIZE-1:0] CANON_QNAN =
    {1'b0, {EXP_SIZE{1'b1}}, 1'b1, {(SIG_SIZE-2){1'b0}}};

  logic              sign;
  logic [EW-1:0]     exp_rec;
  logic [FW-1:0]     frac;
  int                exp_int;
  lane_class_e       cls;
  logic [EW-1:0]     shamt;
  logic [FW-1:0]     sub_frac;
  logic [EXP_SIZE-1:0] exp_ieee;

  assign sign     = rec_i[SIZE];
  assign exp_rec  = rec_i[SIZE-1:FW];
  assign frac     = rec_i[FW-1:0];
  assign exp_int  = int'(exp_rec);

  // For subnormals the hidden one is shifted right by B+2-e (1..SIG_SIZE-1).
  assign shamt    = EW'(NORM_LO) - exp_rec;
  assign sub_frac = FW'({1'b1, frac} >> shamt);
  assign exp_ieee = EXP_SIZE'(exp_rec - EW'(BIAS_P1));

  // Exponents outside every named range collapse to a signed zero.
  always_comb begin
    cls = LC_ZERO;
    if (exp_rec[EW-1 -: 3] == REC_CLS_ZERO) begin
      cls = LC_ZERO;
    end else if (exp_rec[EW-1 -: 3] == REC_CLS_NAN) begin
      cls = LC_NAN;
    end else if (exp_rec[EW-1 -: 2] == REC_CLS_SPECIAL) begin
      cls = LC_INF;
    end else if (exp_int >= NORM_LO && exp_int < NORM_HI) begin
      cls = LC_NORMAL;
    end else if (exp_int >= SUB_LO && exp_int <= SUB_HI) begin
      cls = LC_SUBNORMAL;
    end
  end

  always_comb begin
    value_o = '0;
    snan_o  = 1'b0;
    case (cls)
      LC_NORMAL:    value_o = {sign, exp_ieee, frac};
      LC_SUBNORMAL: value_o = {sign, {EXP_SIZE{1'b0}}, sub_frac};
      LC_INF:       value_o = {sign, {EXP_SIZE{1'b1}}, {FW{1'b0}}};
      LC_NAN: begin
        // Signalling status reflects the input even when the NaN is canonicalised.
        snan_o  = ~frac[FW-1];
        value_o = (CANON_NAN != 0) ? CANON_QNAN : {sign, {EXP_SIZE{1'b1}}, frac};
      end
      default:      value_o = {sign, {(SIZE-1){1'b0}}};
    endcase
  end

endmodule

// File: rtl/recoded_to_ieee_pipe.sv
// LANES-wide recoded-to-IEEE converter followed by a STAGES-deep (1..4)
// elastic register pipeline carrying data, tag and signalling-NaN flags.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake
//   in_data              : LANES recoded values, lane k at [k*(SIZE+1) +: SIZE+1]
//   in_tag               : sideband tag travelling with the beat
//   out_valid/out_ready  : output handshake
//   out_data             : LANES IEEE values, lane k at [k*SIZE +: SIZE]
//   out_tag, out_snan    : tag and per-lane signalling-NaN flags
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high. out_valid/out_data/out_tag/out_snan hold while
// out_valid=1 and out_ready=0. Stage i loads whenever it or any later stage
// is empty, or the output accepts, so bubbles collapse and a full pipe can
// accept and emit in the same cycle. in_ready follows out_ready
// combinationally; in_data only reaches the outputs through registers.
module recoded_to_ieee_pipe
  import recoded_to_ieee_pkg::*;
#(
  parameter int EXP_SIZE  = 8,
  parameter int SIG_SIZE  = 24,
  parameter int LANES     = 1,
  parameter int STAGES    = 2,
  parameter int TAG_W     = 4,
  parameter int CANON_NAN = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [LANES*(EXP_SIZE+SIG_SIZE+1)-1:0] in_data,
  input  logic [TAG_W-1:0]                      in_tag,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [LANES*(EXP_SIZE+SIG_SIZE)-1:0]  out_data,
  output logic [TAG_W-1:0]                      out_tag,
  output logic [LANES-1:0]                      out_snan
);

  localparam int SIZE = EXP_SIZE + SIG_SIZE;
  localparam int DW   = LANES * SIZE;
  localparam int PW   = LANES + TAG_W + DW;   // {snan, tag, data}

  logic [DW-1:0]    conv_data;
  logic [LANES-1:0] conv_snan;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    recoded_to_ieee_lane #(
      .EXP_SIZE  (EXP_SIZE),
      .SIG_SIZE  (SIG_SIZE),
      .CANON_NAN (CANON_NAN)
    ) u_lane (
      .rec_i   (in_data[k*(SIZE+1) +: SIZE+1]),
      .value_o (conv_data[k*SIZE +: SIZE]),
      .snan_o  (conv_snan[k])
    );
  end

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] load;
  logic [PW-1:0]     pay_q [STAGES];
  logic [PW-1:0]     pay_d [STAGES];

  // Stage i may shift if any stage from i to the end has a hole, or the
  // output is taking the last stage this cycle.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      load[i] = out_ready;
      for (int j = i; j < STAGES; j++) begin
        if (!vld_q[j]) load[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      vld_d[i] = vld_q[i];
      pay_d[i] = pay_q[i];
    end
    if (load[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) pay_d[0] = {conv_snan, in_tag, conv_data};
    end
    for (int i = 1; i < STAGES; i++) begin
      if (load[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) pay_d[i] = pay_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) pay_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < STAGES; i++) pay_q[i] <= pay_d[i];
    end
  end

  assign in_ready  = load[0];
  assign out_valid = vld_q[STAGES-1];
  assign {out_snan, out_tag, out_data} = pay_q[STAGES-1];

endmodule

// File: tb/tb_recoded_to_ieee_pipe.sv
module tb_recoded_to_ieee_pipe;

  localparam int ES = 8;
  localparam int SS = 24;
  localparam int SZ = ES + SS;
  localparam int RW = SZ + 1;
  localparam int LN = 4;
  localparam int ST = 2;
  localparam int TW = 4;
  localparam int EW = 2*LN*SZ + LN + TW;   // {raw data, canon data, snan, tag}
  localparam int OFF_SN = TW;
  localparam int OFF_D1 = TW + LN;
  localparam int OFF_D0 = TW + LN + LN*SZ;

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, out_ready;
  logic [LN*RW-1:0] in_data;
  logic [TW-1:0] in_tag;
  logic in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [LN*SZ-1:0] out_data_a, out_data_b;
  logic [TW-1:0] out_tag_a, out_tag_b;
  logic [LN-1:0] out_snan_a, out_snan_b;

  always #5 clk = ~clk;

  recoded_to_ieee_pipe #(.EXP_SIZE(ES), .SIG_SIZE(SS), .LANES(LN), .STAGES(ST),
                         .TAG_W(TW), .CANON_NAN(0)) u_dut_raw (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_tag(out_tag_a), .out_snan(out_snan_a));

  recoded_to_ieee_pipe #(.EXP_SIZE(ES), .SIG_SIZE(SS), .LANES(LN), .STAGES(ST),
                         .TAG_W(TW), .CANON_NAN(1)) u_dut_canon (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_tag(out_tag_b), .out_snan(out_snan_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_out   = 0;
  logic [EW-1:0] exp_q[$];
  int acc_q[$];
  bit lat_chk  = 0;
  bit rand_rdy = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_lane(input logic [RW-1:0] r, input bit canon,
                                     output logic [SZ-1:0] v, output logic sn);
    int b, e;
    logic s;
    logic [SS-2:0] f;
    longint m;
    b  = 1 << (ES - 1);
    s  = r[SZ];
    e  = int'(r[SZ-1:SS-1]);
    f  = r[SS-2:0];
    sn = 1'b0;
    if (e < b/2) begin
      v = {s, 31'd0};
    end else if (e >= 3*b + b/2) begin
      sn = (f[SS-2] == 1'b0);
      v  = canon ? 32'h7FC0_0000 : {s, 8'hFF, f};
    end else if (e >= 3*b) begin
      v = {s, 8'hFF, 23'd0};
    end else if (e >= b + 2) begin
      v = {s, 8'(e - (b + 1)), f};
    end else if (e >= b - SS + 3) begin
      m = ((longint'(1) << (SS - 1)) + longint'(f)) >> (b + 2 - e);
      v = {s, 8'd0, 23'(m)};
    end else begin
      v = {s, 31'd0};
    end
  endfunction

  function automatic logic [EW-1:0] model_beat(input logic [LN*RW-1:0] d, input logic [TW-1:0] t);
    logic [LN*SZ-1:0] d0, d1;
    logic [LN-1:0] sn;
    logic [SZ-1:0] v;
    logic s0, s1;
    for (int k = 0; k < LN; k++) begin
      model_lane(d[k*RW +: RW], 1'b0, v, s0);
      d0[k*SZ +: SZ] = v;
      sn[k] = s0;
      model_lane(d[k*RW +: RW], 1'b1, v, s1);
      d1[k*SZ +: SZ] = v;
    end
    return {d0, d1, sn, t};
  endfunction

  function automatic logic [RW-1:0] rand_lane();
    int b, e;
    b = 1 << (ES - 1);
    case ($urandom_range(0, 9))
      0:       e = $urandom_range(0, b/2 - 1);
      1:       e = $urandom_range(b/2, b - SS + 2);
      2:       e = $urandom_range(b - SS + 3, b + 1);
      3:       e = $urandom_range(3*b, 3*b + b/2 - 1);
      4:       e = $urandom_range(3*b + b/2, 4*b - 1);
      default: e = $urandom_range(b + 2, 3*b - 1);
    endcase
    return {1'($urandom_range(0, 1)), 9'(e), 23'($urandom())};
  endfunction

  function automatic logic [LN*RW-1:0] rand_beat();
    logic [LN*RW-1:0] d;
    for (int k = 0; k < LN; k++) d[k*RW +: RW] = rand_lane();
    return d;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive_beat(input logic [LN*RW-1:0] d, input logic [TW-1:0] t,
                            input logic [EW-1:0] e);
    int w;
    bit done;
    w = 0;
    done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    while (!done) begin
      @(negedge clk);
      if (in_ready_a) begin
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        n_acc++;
        done = 1;
      end else if (++w > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: tag %0d not accepted within 200 cycles", t);
        done = 1;
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check("drain_empty", 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  bit prev_stall = 0;
  logic [LN*SZ-1:0] prev_data;
  logic [TW-1:0] prev_tag;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    int a;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 128'(out_valid_a), 128'd1);
        check("hold_data", out_data_a, prev_data);
        check("hold_tag", 128'(out_tag_a), 128'(prev_tag));
      end
      check("valid_pair", 128'(out_valid_b), 128'(out_valid_a));
      if (out_valid_a && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: tag %0h with empty scoreboard", out_tag_a);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          n_out++;
          check("data_raw",   out_data_a, e[OFF_D0 +: LN*SZ]);
          check("data_canon", out_data_b, e[OFF_D1 +: LN*SZ]);
          check("snan_raw",   128'(out_snan_a), 128'(e[OFF_SN +: LN]));
          check("snan_canon", 128'(out_snan_b), 128'(e[OFF_SN +: LN]));
          check("tag",        128'(out_tag_a), 128'(e[TW-1:0]));
          if (lat_chk) check("latency", 128'(cyc - a), 128'(ST));
        end
      end
      prev_stall = out_valid_a && !out_ready;
      prev_data  = out_data_a;
      prev_tag   = out_tag_a;
    end
  end

  // ---------------- directed vectors ----------------
  logic [RW-1:0] dir_rec [12] = '{
    33'h0_8000_0000, 33'h1_0000_0000, 33'h0_C000_0000, 33'h0_3580_0000,
    33'h0_4080_0000, 33'h0_E000_0001, 33'h0_E040_0000, 33'h1_E000_0002,
    33'h1_5000_0000, 33'h0_BF80_0000, 33'h0_4100_0000, 33'h1_3500_0000};
  logic [SZ-1:0] dir_raw [12] = '{
    32'h3F80_0000, 32'h8000_0000, 32'h7F80_0000, 32'h0000_0001,
    32'h0040_0000, 32'h7F80_0001, 32'h7FC0_0000, 32'hFF80_0002,
    32'h8F80_0000, 32'h7F00_0000, 32'h0080_0000, 32'h8000_0000};
  logic [SZ-1:0] dir_can [12] = '{
    32'h3F80_0000, 32'h8000_0000, 32'h7F80_0000, 32'h0000_0001,
    32'h0040_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000,
    32'h8F80_0000, 32'h7F00_0000, 32'h0080_0000, 32'h8000_0000};
  logic dir_sn [12] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};

  // ---------------- main sequence ----------------
  initial begin
    logic [LN*RW-1:0] d;
    logic [LN*SZ-1:0] d0, d1;
    logic [LN-1:0] sn;

    rst_n = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_tag = '0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(out_valid_a), 128'd0);
    check("rst_out_data",  out_data_a, 128'd0);
    check("rst_out_tag",   128'(out_tag_a), 128'd0);
    check("rst_out_snan",  128'(out_snan_a), 128'd0);
    check("rst_in_ready",  128'({in_ready_a, in_ready_b}), 128'd3);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed conversions, unstalled, with exact latency.
    out_ready = 1'b1;
    lat_chk = 1;
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < LN; k++) begin
        d[k*RW +: RW]  = dir_rec[j*LN + k];
        d0[k*SZ +: SZ] = dir_raw[j*LN + k];
        d1[k*SZ +: SZ] = dir_can[j*LN + k];
        sn[k]          = dir_sn[j*LN + k];
      end
      drive_beat(d, TW'(j + 8), {d0, d1, sn, TW'(j + 8)});
    end
    drain();
    lat_chk = 0;

    // Stall: two beats fill the pipe, a third must wait.
    out_ready = 1'b0;
    d = rand_beat();
    drive_beat(d, 4'd1, model_beat(d, 4'd1));
    d = rand_beat();
    drive_beat(d, 4'd2, model_beat(d, 4'd2));
    d = rand_beat();
    in_valid = 1'b1;
    in_data = d;
    in_tag = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 128'(in_ready_a), 128'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 128'(in_ready_a), 128'd1);
    check("release_out0", 128'({out_valid_a, out_tag_a}), 128'({1'b1, 4'd1}));
    exp_q.push_back(model_beat(d, 4'd3));
    acc_q.push_back(cyc);
    n_acc++;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("release_out1", 128'({out_valid_a, out_tag_a}), 128'({1'b1, 4'd2}));
    @(negedge clk);
    check("release_out2", 128'({out_valid_a, out_tag_a}), 128'({1'b1, 4'd3}));
    drain();

    // Reset with beats in flight.
    out_ready = 1'b0;
    d = rand_beat();
    drive_beat(d, 4'd4, model_beat(d, 4'd4));
    d = rand_beat();
    drive_beat(d, 4'd5, model_beat(d, 4'd5));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'({out_valid_a, out_valid_b}), 128'd0);
    check("midrst_out_data",  out_data_a, 128'd0);
    check("midrst_out_tag",   128'(out_tag_a), 128'd0);
    check("midrst_in_ready",  128'(in_ready_a), 128'd1);
    n_acc -= exp_q.size();
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 128'(out_valid_a), 128'd0);
    @(posedge clk);
    #1;
    d = rand_beat();
    drive_beat(d, 4'd6, model_beat(d, 4'd6));
    d = rand_beat();
    drive_beat(d, 4'd7, model_beat(d, 4'd7));
    drain();

    // Random stream with random back-pressure.
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) step();
      d = rand_beat();
      drive_beat(d, TW'(i), model_beat(d, TW'(i)));
    end
    rand_rdy = 0;
    out_ready = 1'b1;
    drain();
    check("accounting", 128'(n_out), 128'(n_acc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
